// File: rtl/hazard3_trigger_unit.sv
// Debug trigger unit: mcontrol (exact/NAPOT address) and icount triggers behind the
// tselect/tdata1/tdata2/tinfo CSR window, producing break requests for the core.
module hazard3_trigger_unit #(
  parameter int unsigned N_TRIGGERS = 4,
  parameter int unsigned W_DATA     = 32,
  parameter int unsigned ICOUNT_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       cfg_addr,
  input  logic              cfg_wen,
  input  logic [W_DATA-1:0] cfg_wdata,
  output logic [W_DATA-1:0] cfg_rdata,
  input  logic              trig_m_en,
  input  logic              m_mode,
  input  logic              d_mode,
  input  logic [W_DATA-1:0] pc,
  input  logic              pc_valid,
  input  logic              instr_ret,
  input  logic [W_DATA-1:0] ls_addr,
  input  logic              ls_valid,
  input  logic              ls_write,
  input  logic              break_ack,
  output logic              break_any,
  output logic              break_d_mode
);

  localparam logic [11:0] AddrTselect = 12'h7a0;
  localparam logic [11:0] AddrTdata1  = 12'h7a1;
  localparam logic [11:0] AddrTdata2  = 12'h7a2;
  localparam logic [11:0] AddrTinfo   = 12'h7a4;

  logic [2:0]            tselect_q, tselect_d;
  // type_q: 0 = mcontrol (type 2), 1 = icount (type 3)
  logic [N_TRIGGERS-1:0] type_q, type_d;
  logic [N_TRIGGERS-1:0] dmode_q, dmode_d;
  logic [N_TRIGGERS-1:0] hit_q, hit_d;
  logic [N_TRIGGERS-1:0] action_q, action_d;
  logic [N_TRIGGERS-1:0] napot_q, napot_d;
  logic [N_TRIGGERS-1:0] m_q, m_d;
  logic [N_TRIGGERS-1:0] u_q, u_d;
  logic [N_TRIGGERS-1:0] exec_q, exec_d;
  logic [N_TRIGGERS-1:0] store_q, store_d;
  logic [N_TRIGGERS-1:0] load_q, load_d;
  logic [N_TRIGGERS-1:0] pending_q, pending_d;
  logic [W_DATA-1:0]     tdata2_q [N_TRIGGERS];
  logic [W_DATA-1:0]     tdata2_d [N_TRIGGERS];
  logic [ICOUNT_W-1:0]   count_q [N_TRIGGERS];
  logic [ICOUNT_W-1:0]   count_d [N_TRIGGERS];

  logic [N_TRIGGERS-1:0] csr_sel;
  logic [N_TRIGGERS-1:0] wr_ok;
  logic [N_TRIGGERS-1:0] armed;
  logic [N_TRIGGERS-1:0] exec_hit;
  logic [N_TRIGGERS-1:0] ls_hit;
  logic [N_TRIGGERS-1:0] ic_dec;
  logic [N_TRIGGERS-1:0] ic_fire;
  logic [31:0]           wd;
  logic [31:0]           rd_t1;
  logic [W_DATA-1:0]     rd_t2;

  assign wd = cfg_wdata[31:0];

  // NAPOT: trailing ones of tdata2 plus the first zero above them are don't-care bits.
  function automatic logic addr_match(input logic [W_DATA-1:0] tdata2,
                                      input logic [W_DATA-1:0] addr,
                                      input logic              napot);
    logic [W_DATA-1:0] mask;
    mask = napot ? (tdata2 ^ (tdata2 + W_DATA'(1))) : '0;
    return ((addr ^ tdata2) & ~mask) == '0;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_TRIGGERS; i++) begin
      csr_sel[i]  = tselect_q == 3'(i);
      wr_ok[i]    = cfg_wen && csr_sel[i] && (!dmode_q[i] || d_mode);
      armed[i]    = !d_mode && (m_mode ? m_q[i] : u_q[i]) &&
                    (action_q[i] ? dmode_q[i] : trig_m_en);
      exec_hit[i] = !type_q[i] && exec_q[i] && armed[i] && pc_valid &&
                    addr_match(tdata2_q[i], pc, napot_q[i]);
      ls_hit[i]   = !type_q[i] && armed[i] && ls_valid &&
                    (ls_write ? store_q[i] : load_q[i]) &&
                    addr_match(tdata2_q[i], ls_addr, napot_q[i]);
      ic_dec[i]   = type_q[i] && armed[i] && instr_ret && (count_q[i] != '0);
      ic_fire[i]  = ic_dec[i] && (count_q[i] == ICOUNT_W'(1));
    end
  end

  always_comb begin
    tselect_d = tselect_q;
    type_d    = type_q;
    dmode_d   = dmode_q;
    hit_d     = hit_q;
    action_d  = action_q;
    napot_d   = napot_q;
    m_d       = m_q;
    u_d       = u_q;
    exec_d    = exec_q;
    store_d   = store_q;
    load_d    = load_q;
    pending_d = pending_q;
    tdata2_d  = tdata2_q;
    count_d   = count_q;

    if (cfg_wen && cfg_addr == AddrTselect) begin
      tselect_d = wd[2:0];
    end

    for (int unsigned i = 0; i < N_TRIGGERS; i++) begin
      if (wr_ok[i] && cfg_addr == AddrTdata1) begin
        if (wd[31:28] == 4'd3) begin
          type_d[i] = 1'b1;
        end else if (wd[31:28] == 4'd2) begin
          type_d[i] = 1'b0;
        end
        if (d_mode) begin
          dmode_d[i] = wd[27];
        end
        // Field layout follows the type that results from this write.
        if (type_d[i]) begin
          hit_d[i]    = wd[24];
          count_d[i]  = wd[ICOUNT_W+9:10];
          m_d[i]      = wd[9];
          u_d[i]      = wd[6];
          action_d[i] = wd[0];
        end else begin
          hit_d[i]    = wd[20];
          action_d[i] = wd[12];
          napot_d[i]  = wd[10:7] == 4'd1;
          m_d[i]      = wd[6];
          u_d[i]      = wd[3];
          exec_d[i]   = wd[2];
          store_d[i]  = wd[1];
          load_d[i]   = wd[0];
        end
      end
      if (wr_ok[i] && cfg_addr == AddrTdata2) begin
        tdata2_d[i] = cfg_wdata;
      end

      // Hardware updates below override any same-cycle CSR write.
      if (ic_dec[i]) begin
        count_d[i] = count_q[i] - ICOUNT_W'(1);
      end
      if (exec_hit[i] || ls_hit[i] || ic_fire[i]) begin
        hit_d[i] = 1'b1;
      end

      if (d_mode) begin
        pending_d[i] = 1'b0;
      end else if (ls_hit[i] || ic_fire[i]) begin
        pending_d[i] = 1'b1;
      end else if (break_ack) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tselect_q <= '0;
      type_q    <= '0;
      dmode_q   <= '0;
      hit_q     <= '0;
      action_q  <= '0;
      napot_q   <= '0;
      m_q       <= '0;
      u_q       <= '0;
      exec_q    <= '0;
      store_q   <= '0;
      load_q    <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < N_TRIGGERS; i++) begin
        tdata2_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      tselect_q <= tselect_d;
      type_q    <= type_d;
      dmode_q   <= dmode_d;
      hit_q     <= hit_d;
      action_q  <= action_d;
      napot_q   <= napot_d;
      m_q       <= m_d;
      u_q       <= u_d;
      exec_q    <= exec_d;
      store_q   <= store_d;
      load_q    <= load_d;
      pending_q <= pending_d;
      tdata2_q  <= tdata2_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    rd_t1 = '0;
    rd_t2 = '0;
    for (int unsigned i = 0; i < N_TRIGGERS; i++) begin
      if (csr_sel[i]) begin
        if (type_q[i]) begin
          rd_t1[31:28]          = 4'd3;
          rd_t1[27]             = dmode_q[i];
          rd_t1[24]             = hit_q[i];
          rd_t1[ICOUNT_W+9:10]  = count_q[i];
          rd_t1[9]              = m_q[i];
          rd_t1[6]              = u_q[i];
          rd_t1[0]              = action_q[i];
        end else begin
          rd_t1[31:28] = 4'd2;
          rd_t1[27]    = dmode_q[i];
          rd_t1[26:21] = 6'h1f;
          rd_t1[20]    = hit_q[i];
          rd_t1[12]    = action_q[i];
          rd_t1[7]     = napot_q[i];
          rd_t1[6]     = m_q[i];
          rd_t1[3]     = u_q[i];
          rd_t1[2]     = exec_q[i];
          rd_t1[1]     = store_q[i];
          rd_t1[0]     = load_q[i];
        end
        rd_t2 = tdata2_q[i];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      AddrTselect: cfg_rdata = W_DATA'(tselect_q);
      AddrTdata1:  cfg_rdata = W_DATA'(rd_t1);
      AddrTdata2:  cfg_rdata = rd_t2;
      AddrTinfo:   cfg_rdata = (|csr_sel) ? W_DATA'(32'h0000_000c) : W_DATA'(32'h0000_0001);
      default:     cfg_rdata = '0;
    endcase
  end

  // Pending flags are masked in debug mode so entry never raises a break.
  assign break_any    = (|exec_hit) || (!d_mode && (|pending_q));
  assign break_d_mode = (|(exec_hit & action_q)) || (!d_mode && (|(pending_q & action_q)));

endmodule

// File: tb/tb_hazard3_trigger_unit.sv
// Directed bench for hazard3_trigger_unit: CSR access, execute/NAPOT/icount triggers,
// dmode protection, ack collision and asynchronous reset.
module tb_hazard3_trigger_unit;

  localparam logic [11:0] TSEL = 12'h7a0;
  localparam logic [11:0] TD1  = 12'h7a1;
  localparam logic [11:0] TD2  = 12'h7a2;
  localparam logic [11:0] TINF = 12'h7a4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cfg_addr;
  logic        cfg_wen;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        trig_m_en, m_mode, d_mode;
  logic [31:0] pc;
  logic        pc_valid, instr_ret;
  logic [31:0] ls_addr;
  logic        ls_valid, ls_write, break_ack;
  logic        break_any, break_d_mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard3_trigger_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_addr     (cfg_addr),
    .cfg_wen      (cfg_wen),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .trig_m_en    (trig_m_en),
    .m_mode       (m_mode),
    .d_mode       (d_mode),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .instr_ret    (instr_ret),
    .ls_addr      (ls_addr),
    .ls_valid     (ls_valid),
    .ls_write     (ls_write),
    .break_ack    (break_ack),
    .break_any    (break_any),
    .break_d_mode (break_d_mode)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wen   = 1'b1;
    tick();
    cfg_wen   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check_eq(tag, cfg_rdata, exp);
  endtask

  task automatic brk_chk(input string tag, input logic exp_any, input logic exp_d);
    #1;
    check_eq({tag, "_any"}, {31'd0, break_any}, {31'd0, exp_any});
    check_eq({tag, "_dm"}, {31'd0, break_d_mode}, {31'd0, exp_d});
  endtask

  initial begin
    rst_n = 1'b0; cfg_addr = TSEL; cfg_wen = 1'b0; cfg_wdata = '0;
    trig_m_en = 1'b0; m_mode = 1'b1; d_mode = 1'b0; pc = '0; pc_valid = 1'b0;
    instr_ret = 1'b0; ls_addr = '0; ls_valid = 1'b0; ls_write = 1'b0; break_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and CSR window
    brk_chk("rst_brk", 1'b0, 1'b0);
    rd_chk("rst_tsel", TSEL, 32'h0);
    rd_chk("rst_td1", TD1, 32'h23e0_0000);
    rd_chk("rst_td2", TD2, 32'h0);
    rd_chk("rst_tinfo", TINF, 32'h0000_000c);
    csr_wr(TSEL, 32'h0000_0005);
    rd_chk("tsel5", TSEL, 32'h5);
    rd_chk("tsel5_td1", TD1, 32'h0);
    rd_chk("tsel5_tinfo", TINF, 32'h1);
    csr_wr(TSEL, 32'h0);

    // Execute trigger, exact match, fires combinationally
    trig_m_en = 1'b1;
    csr_wr(TD2, 32'h0000_1000);
    csr_wr(TD1, 32'h2000_0044);
    rd_chk("exe_td1", TD1, 32'h23e0_0044);
    pc = 32'h0000_1004; pc_valid = 1'b1;
    brk_chk("exe_miss", 1'b0, 1'b0);
    pc = 32'h0000_1000;
    brk_chk("exe_hit", 1'b1, 1'b0);
    tick();
    pc_valid = 1'b0;
    brk_chk("exe_after", 1'b0, 1'b0);
    rd_chk("exe_hitbit", TD1, 32'h23f0_0044);
    csr_wr(TD1, 32'h2000_0000);
    rd_chk("exe_clr", TD1, 32'h23e0_0000);

    // NAPOT store trigger on trigger 1: 0x2000..0x200f
    csr_wr(TSEL, 32'h1);
    csr_wr(TD2, 32'h0000_2007);
    csr_wr(TD1, 32'h2000_00c2);
    ls_addr = 32'h0000_200c; ls_write = 1'b1; ls_valid = 1'b1;
    brk_chk("st_same", 1'b0, 1'b0);
    tick();
    ls_valid = 1'b0;
    brk_chk("st_next", 1'b1, 1'b0);
    tick();
    brk_chk("st_hold", 1'b1, 1'b0);
    rd_chk("st_hitbit", TD1, 32'h23f0_00c2);
    break_ack = 1'b1;
    tick();
    break_ack = 1'b0;
    brk_chk("st_ack", 1'b0, 1'b0);
    ls_addr = 32'h0000_2010; ls_valid = 1'b1;
    tick();
    ls_valid = 1'b0;
    brk_chk("st_out", 1'b0, 1'b0);
    ls_addr = 32'h0000_200c; ls_write = 1'b0; ls_valid = 1'b1;
    tick();
    ls_valid = 1'b0;
    brk_chk("ld_nold", 1'b0, 1'b0);

    // Ack collides with a new load match; pending wins. Then D-mode entry clears it.
    csr_wr(TD1, 32'h2000_00c3);
    rd_chk("col_td1", TD1, 32'h23e0_00c3);
    ls_addr = 32'h0000_2004; ls_write = 1'b0; ls_valid = 1'b1;
    tick();
    ls_valid = 1'b0;
    brk_chk("col_pend", 1'b1, 1'b0);
    ls_valid = 1'b1; break_ack = 1'b1;
    tick();
    ls_valid = 1'b0; break_ack = 1'b0;
    brk_chk("col_keep", 1'b1, 1'b0);
    d_mode = 1'b1;
    brk_chk("dent_mask", 1'b0, 1'b0);
    tick();
    d_mode = 1'b0;
    brk_chk("dent_clr", 1'b0, 1'b0);
    csr_wr(TD1, 32'h2000_0000);

    // icount on trigger 2
    csr_wr(TSEL, 32'h2);
    csr_wr(TD1, 32'h3000_0e00);
    rd_chk("ic_td1", TD1, 32'h3000_0e00);
    instr_ret = 1'b1; tick(); instr_ret = 1'b0;
    rd_chk("ic_cnt2", TD1, 32'h3000_0a00);
    instr_ret = 1'b1; tick(); instr_ret = 1'b0;
    rd_chk("ic_cnt1", TD1, 32'h3000_0600);
    brk_chk("ic_nobrk", 1'b0, 1'b0);
    instr_ret = 1'b1; tick(); instr_ret = 1'b0;
    rd_chk("ic_cnt0", TD1, 32'h3100_0200);
    brk_chk("ic_brk", 1'b1, 1'b0);
    instr_ret = 1'b1; tick(); instr_ret = 1'b0;
    rd_chk("ic_stay0", TD1, 32'h3100_0200);
    break_ack = 1'b1; tick(); break_ack = 1'b0;
    brk_chk("ic_ack", 1'b0, 1'b0);

    // dmode protection on trigger 3 (action=1 targets D-mode)
    csr_wr(TSEL, 32'h3);
    d_mode = 1'b1;
    csr_wr(TD2, 32'h0000_3000);
    csr_wr(TD1, 32'h2800_1044);
    rd_chk("dm_td1", TD1, 32'h2be0_1044);
    pc = 32'h0000_3000; pc_valid = 1'b1;
    brk_chk("dm_nofire", 1'b0, 1'b0);
    pc_valid = 1'b0;
    d_mode = 1'b0;
    csr_wr(TD2, 32'h0);
    rd_chk("dm_td2_keep", TD2, 32'h0000_3000);
    csr_wr(TD1, 32'h2000_0000);
    rd_chk("dm_td1_keep", TD1, 32'h2be0_1044);
    pc_valid = 1'b1;
    brk_chk("dm_fire", 1'b1, 1'b1);
    pc_valid = 1'b0;
    tick();

    // Asynchronous reset with count=5 and a pending icount break
    csr_wr(TSEL, 32'h2);
    csr_wr(TD1, 32'h3000_0600);
    instr_ret = 1'b1; tick(); instr_ret = 1'b0;
    csr_wr(TD1, 32'h3000_1600);
    rd_chk("ar_cnt5", TD1, 32'h3000_1600);
    brk_chk("ar_pend", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    brk_chk("ar_brk", 1'b0, 1'b0);
    rd_chk("ar_tsel", TSEL, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    csr_wr(TSEL, 32'h2);
    rd_chk("ar_td1", TD1, 32'h23e0_0000);
    brk_chk("ar_after", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard3_trigger_unit.md
HAZARD3_TRIGGER_UNIT -- requirements
Module: hazard3_trigger_unit

Interface
REQ-001 SHALL have parameter N_TRIGGERS, default 4, number of triggers (1-8).
REQ-002 SHALL have parameter W_DATA, default 32, CSR and address width.
REQ-003 SHALL have parameter ICOUNT_W, default 14, width of icount count field.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  cfg_addr  in  12  CSR address (TSELECT 0x7a0, TDATA1 0x7a1, TDATA2 0x7a2, TINFO 0x7a4)
  cfg_wen  in  1  CSR write strobe
  cfg_wdata  in  W_DATA  CSR write data
  cfg_rdata  out  W_DATA  CSR read data, combinational from cfg_addr
  trig_m_en  in  1  global enable for action=0 (M-mode) breaks
  m_mode, d_mode  in  1 each  current privilege / debug mode
  pc  in  W_DATA  address of instruction in decode
  pc_valid  in  1  pc is a real instruction this cycle
  instr_ret  in  1  one instruction retired this cycle
  ls_addr  in  W_DATA  load/store address
  ls_valid  in  1  load/store completes this cycle
  ls_write  in  1  1 = store, 0 = load
  break_ack  in  1  core has taken pending break
  break_any  out  1  break request, any action
  break_d_mode  out  1  break request targets D-mode

Function
REQ-005 SHALL store tselect from cfg_wdata[2:0] on TSELECT write; read returns it zero-extended; values >= N_TRIGGERS read tdata1/tdata2 as 0 and tinfo as 1.
REQ-006 SHALL give each trigger a type of 2 (mcontrol) or 3 (icount); TDATA1 write with wdata[31:28] of 2/3 sets type, other values leave type unchanged, remaining fields written regardless.
REQ-007 SHALL ignore TDATA1/TDATA2 writes to a trigger with dmode=1 when d_mode=0; dmode (bit 27) writable only in d_mode.
REQ-008 SHALL implement mcontrol fields: dmode[27], maskmax[26:21]=0x1f read-only, hit[20], action[12] (1 bit, [15:13]=0), match[10:7] (0 exact, 1 NAPOT; other values store 0), m[6], u[3], execute[2], store[1], load[0]; all other bits read 0.
REQ-009 SHALL implement icount fields: dmode[27], hit[24], count[ICOUNT_W+9:10], m[9], u[6], action[0]; all other bits read 0.
REQ-010 SHALL return tinfo = 0x0000000c for implemented triggers.
REQ-011 SHALL match NAPOT as: k = count of trailing ones in tdata2; address bits [k:0] ignored; tdata2 all-ones matches any address.
REQ-012 SHALL arm a trigger only when !d_mode and (m_mode ? m : u) is set; action=1 additionally requires dmode=1, action=0 requires trig_m_en.
REQ-013 SHALL raise execute break (timing before) combinationally in the same cycle as pc_valid with matching pc; no register stage.
REQ-014 SHALL record load/store match (store with ls_write=1, load with ls_write=0) into a per-trigger pending flag on the clock edge; break asserts the following cycle (timing after) and holds until break_ack.
REQ-015 SHALL decrement icount count on each instr_ret while armed and count > 0; transition 1->0 sets pending; count 0 never decrements or wraps.
REQ-016 SHALL set hit on the edge where a trigger fires (execute match with pc_valid, pending set); hit cleared only by CSR write of 0.
REQ-017 SHALL give hardware hit/pending set priority over a same-cycle CSR write or break_ack clear.
REQ-018 SHALL clear all pending flags on break_ack; break_any = OR of execute matches and pending flags; break_d_mode = OR of those with action=1.
REQ-019 SHALL clear pending flags on entry (d_mode=1) without asserting break.

Reset
REQ-020 SHALL on rst_n low asynchronously clear tselect, all fields, tdata2, counts, hit and pending; type resets to 2; break_any and break_d_mode low from reset.

Verification
REQ-021 Execute: trig0 tdata2=0x1000, execute=1, m=1, action=0, trig_m_en=1, m_mode=1, pc=0x1000 pc_valid=1 -> break_any=1 same cycle, break_d_mode=0, hit=1 next cycle.
REQ-022 NAPOT store: tdata2=0x2007, match=1, store=1; store ls_addr=0x200c -> break_any=1 next cycle, held until break_ack; ls_addr=0x2010 -> no break.
REQ-023 icount: type=3, count=3, m=1, three instr_ret pulses -> count 2,1,0, break_any=1 after third; fourth pulse leaves count 0.
REQ-024 dmode protection: trigger with dmode=1, d_mode=0 write tdata2=0 -> tdata2 unchanged; d_mode=1 -> no matches fire.
REQ-025 Collision: break_ack and new load match same cycle -> pending remains set, break_any stays 1.
REQ-026 Reset mid-count: rst_n low with count=5, pending=1 -> break_any=0, count=0, type=2 immediately.
